// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states and op-class helpers.
package mdu_ctrl_pkg;

    localparam logic [2:0] MDU_NONE  = 3'd0;
    localparam logic [2:0] MDU_MULT  = 3'd1;
    localparam logic [2:0] MDU_MULTU = 3'd2;
    localparam logic [2:0] MDU_DIV   = 3'd3;
    localparam logic [2:0] MDU_DIVU  = 3'd4;
    localparam logic [2:0] MDU_MTHI  = 3'd5;
    localparam logic [2:0] MDU_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } mdu_state_e;

    function automatic logic is_mul_op(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// EX-stage command bus into the MDU plus its status and HI/LO read-out.
interface mdu_ctrl_if;
    logic        start;
    logic [2:0]  mductr;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, mductr, a, b, input busy, stall, hi, lo);
    modport slave  (input start, mductr, a, b, output busy, stall, hi, lo);
endinterface

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath for MULT/MULTU/DIV/DIVU.
// Zero latency; no backpressure (pure function of op/a/b).
// div0 flags a divide by zero so the sequencer can suppress the HI/LO update.
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div0
);

    logic [63:0] sprod;
    logic [63:0] uprod;
    logic        sdiv;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] divisor;
    logic [31:0] uquo;
    logic [31:0] urem;
    logic [31:0] quo;
    logic [31:0] rem;

    // Sign-extended operands give the two's-complement product in the low 64 bits.
    assign sprod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign uprod = {32'd0, a} * {32'd0, b};

    // Signed divide runs on magnitudes; 0x80000000 / -1 wraps naturally back to 0x80000000.
    assign sdiv    = (op == MDU_DIV);
    assign mag_a   = (sdiv && a[31]) ? (32'd0 - a) : a;
    assign mag_b   = (sdiv && b[31]) ? (32'd0 - b) : b;
    assign divisor = (mag_b == 32'd0) ? 32'd1 : mag_b;
    assign uquo    = mag_a / divisor;
    assign urem    = mag_a % divisor;
    assign quo     = (sdiv && (a[31] ^ b[31])) ? (32'd0 - uquo) : uquo;
    assign rem     = (sdiv && a[31]) ? (32'd0 - urem) : urem;

    assign div0 = is_div_op(op) && (b == 32'd0);

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (op)
            MDU_MULT: begin
                res_hi = sprod[63:32];
                res_lo = sprod[31:0];
            end
            MDU_MULTU: begin
                res_hi = uprod[63:32];
                res_lo = uprod[31:0];
            end
            MDU_DIV, MDU_DIVU: begin
                res_hi = rem;
                res_lo = quo;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU sequencer: owns HI/LO, models MULT/DIV latency with a countdown.
// Latency MULT_CYCLES / DIV_CYCLES busy cycles; MTHI/MTLO write at the issue edge.
// No queueing: commands arriving while busy are dropped, stall tells the hazard unit to hold them.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    mdu_ctrl_if.slave  mdu
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    mdu_state_e  state;
    logic [CW-1:0] cnt;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    logic        pend_wr;

    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        div0;
    logic        long_op;

    mdu_arith u_arith (
        .op     (mdu.mductr),
        .a      (mdu.a),
        .b      (mdu.b),
        .res_hi (res_hi),
        .res_lo (res_lo),
        .div0   (div0)
    );

    assign long_op   = is_mul_op(mdu.mductr) || is_div_op(mdu.mductr);
    assign mdu.busy  = (state != ST_IDLE);
    assign mdu.stall = mdu.busy || (mdu.start && long_op);
    assign mdu.hi    = hi_q;
    assign mdu.lo    = lo_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mdu.start) begin
                        case (mdu.mductr)
                            MDU_MULT, MDU_MULTU: begin
                                state   <= ST_MUL;
                                cnt     <= CW'(MULT_CYCLES);
                                pend_hi <= res_hi;
                                pend_lo <= res_lo;
                                pend_wr <= 1'b1;
                            end
                            MDU_DIV, MDU_DIVU: begin
                                state   <= ST_DIV;
                                cnt     <= CW'(DIV_CYCLES);
                                pend_hi <= res_hi;
                                pend_lo <= res_lo;
                                // Divide by zero still burns the full latency but leaves HI/LO alone.
                                pend_wr <= ~div0;
                            end
                            MDU_MTHI: hi_q <= mdu.a;
                            MDU_MTLO: lo_q <= mdu.a;
                            default: ;
                        endcase
                    end
                end
                default: begin
                    if (cnt == CW'(1)) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        if (pend_wr) begin
                            hi_q <= pend_hi;
                            lo_q <= pend_lo;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a remaining-cycles / 64-bit arithmetic reference model.
module tb_mdu_ctrl;

    localparam int NMUL = 5;
    localparam int NDIV = 10;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mdu_ctrl_if bus ();

    mdu_ctrl #(
        .MULT_CYCLES (NMUL),
        .DIV_CYCLES  (NDIV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .mdu   (bus)
    );

    int checks = 0;
    int errors = 0;

    int          m_left;
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    bit          m_pwr;
    bit          chk_on;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference arithmetic in 64-bit signed integers.
    task automatic ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                              output logic [31:0] rhi, output logic [31:0] rlo, output bit wr);
        longint sa, sb, ua, ub, p, q, r;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        rhi = 32'd0;
        rlo = 32'd0;
        wr  = 1'b1;
        case (op)
            OP_MULT:  begin p = sa * sb; rhi = p[63:32]; rlo = p[31:0]; end
            OP_MULTU: begin p = ua * ub; rhi = p[63:32]; rlo = p[31:0]; end
            OP_DIV: begin
                if (b == 32'd0) wr = 1'b0;
                else begin q = sa / sb; r = sa % sb; rlo = q[31:0]; rhi = r[31:0]; end
            end
            default: begin
                if (b == 32'd0) wr = 1'b0;
                else begin q = ua / ub; r = ua % ub; rlo = q[31:0]; rhi = r[31:0]; end
            end
        endcase
    endtask

    // One clock: drive at negedge, compare outputs, then advance the model at the edge.
    task automatic step(input bit rst, input bit st, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b);
        bit exp_stall;
        @(negedge clk);
        reset      = rst;
        bus.start  = st;
        bus.mductr = op;
        bus.a      = a;
        bus.b      = b;
        #1;
        if (chk_on) begin
            exp_stall = (m_left > 0) || (st && op >= OP_MULT && op <= OP_DIVU);
            chk("busy",  {31'd0, bus.busy},  {31'd0, m_left > 0});
            chk("stall", {31'd0, bus.stall}, {31'd0, exp_stall});
            chk("hi", bus.hi, m_hi);
            chk("lo", bus.lo, m_lo);
        end
        @(posedge clk);
        if (rst) begin
            m_left = 0; m_hi = 32'd0; m_lo = 32'd0; m_pwr = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_pwr) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (st) begin
            case (op)
                OP_MULT, OP_MULTU: begin m_left = NMUL; ref_result(op, a, b, m_phi, m_plo, m_pwr); end
                OP_DIV, OP_DIVU:   begin m_left = NDIV; ref_result(op, a, b, m_phi, m_plo, m_pwr); end
                OP_MTHI: m_hi = a;
                OP_MTLO: m_lo = a;
                default: ;
            endcase
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, OP_NONE, 32'd0, 32'd0);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        step(1'b0, 1'b1, op, a, b);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 20));
            5:       return 32'd0 - 32'($urandom_range(1, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        chk_on = 1'b0;
        m_left = 0; m_hi = 32'd0; m_lo = 32'd0; m_phi = 32'd0; m_plo = 32'd0; m_pwr = 1'b0;
        step(1'b1, 1'b0, OP_NONE, 32'd0, 32'd0);
        step(1'b1, 1'b1, OP_MULT, 32'd3, 32'd3);
        chk_on = 1'b1;
        #1;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        idle(2);

        // MULT -3 * 5
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
        idle(NMUL);
        #1;
        chk("t1_busy", {31'd0, bus.busy}, 32'd0);
        chk("t1_hi", bus.hi, 32'hFFFF_FFFF);
        chk("t1_lo", bus.lo, 32'hFFFF_FFF1);

        // MULTU 0xFFFFFFFF * 2
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        idle(NMUL);
        #1;
        chk("t2_hi", bus.hi, 32'h0000_0001);
        chk("t2_lo", bus.lo, 32'hFFFF_FFFE);

        // DIV -7 / 2, then DIVU by zero
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        idle(NDIV);
        #1;
        chk("t3_lo", bus.lo, 32'hFFFF_FFFD);
        chk("t3_hi", bus.hi, 32'hFFFF_FFFF);
        issue(OP_DIVU, 32'd7, 32'd0);
        idle(NDIV);
        #1;
        chk("t3z_lo", bus.lo, 32'hFFFF_FFFD);
        chk("t3z_hi", bus.hi, 32'hFFFF_FFFF);

        // Overflowing signed divide wraps
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        idle(NDIV);
        #1;
        chk("ovf_lo", bus.lo, 32'h8000_0000);
        chk("ovf_hi", bus.hi, 32'd0);

        // MTHI in idle; MTLO during a MULT is dropped
        issue(OP_MTHI, 32'h1234_5678, 32'd0);
        #1;
        chk("t4_hi", bus.hi, 32'h1234_5678);
        chk("t4_busy", {31'd0, bus.busy}, 32'd0);
        issue(OP_MULT, 32'd3, 32'd4);
        idle(1);
        issue(OP_MTLO, 32'd1, 32'd0);
        idle(NMUL - 2);
        #1;
        chk("t4_lo", bus.lo, 32'd12);
        chk("t4_mhi", bus.hi, 32'd0);

        // MULT issued at busy cycle 3 of a DIV is dropped
        issue(OP_DIV, 32'd100, 32'd7);
        idle(2);
        issue(OP_MULT, 32'd9, 32'd9);
        idle(NDIV - 3);
        #1;
        chk("t5_busy", {31'd0, bus.busy}, 32'd0);
        chk("t5_lo", bus.lo, 32'd14);
        chk("t5_hi", bus.hi, 32'd2);
        idle(2);

        // Reset at busy cycle 4 of a DIV discards the pending result
        issue(OP_DIV, 32'd50, 32'd3);
        idle(3);
        step(1'b1, 1'b0, OP_NONE, 32'd0, 32'd0);
        #1;
        chk("t6_busy", {31'd0, bus.busy}, 32'd0);
        chk("t6_hi", bus.hi, 32'd0);
        chk("t6_lo", bus.lo, 32'd0);
        idle(NDIV + 2);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0),
                 3'($urandom_range(0, 7)), pick(), pick());
        end
        idle(NDIV + 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
